// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Purpose  : Shared definitions for the HI/LO multiply/divide unit.
//            - 3-bit op codes accepted on the op port
//            - FSM state encoding of the divide sequencer
// Config   : HILO_MADD_EN adds the signedness selector for the
//            multiply-accumulate op codes 6/7.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;
    localparam logic [2:0] c_op_madd  = 3'd6;
    localparam logic [2:0] c_op_msub  = 3'd7;

`ifdef HILO_MADD_EN
    // The op field has no spare bit for MADDU/MSUBU, so the accumulate
    // codes share one build-time signedness: 0 = signed, 1 = unsigned.
    localparam logic c_madd_unsigned = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIV_RUN = 2'd1,
        ST_DIV_FIX = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Unsigned W-bit restoring divider, one quotient bit per cycle.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start           - load dividend/divisor, begin W iterations
//            cancel          - abandon the current division
//            dividend/divisor- unsigned operands (divisor must be non-zero)
//            last            - high in the cycle whose edge produces the final
//                              quotient bit (combinational)
//            quotient/remainder - results, valid after the 'last' edge
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cancel,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         last,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    logic [W-1:0]     r_quo;
    logic [W-1:0]     r_rem;
    logic [W-1:0]     r_dsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    logic [W:0] w_part;
    logic [W:0] w_diff;

    // Shift the next dividend bit into the partial remainder; the borrow
    // out of the trial subtraction decides the quotient bit.
    assign w_part    = {r_rem, r_quo[W-1]};
    assign w_diff    = w_part - {1'b0, r_dsr};
    assign last      = r_run && (r_cnt == CNT_W'(W - 1));
    assign quotient  = r_quo;
    assign remainder = r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (cancel) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dsr <= divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            if (!w_diff[W]) begin
                r_rem <= w_diff[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b1};
            end else begin
                r_rem <= w_part[W-1:0];
                r_quo <= {r_quo[W-2:0], 1'b0};
            end
            if (last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv_unit
// Purpose  : HI/LO register block with single-cycle multiplier and iterative
//            divider for the EX stage.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start, op      - op valid / op code (ignored while busy)
//            cancel         - EX flush, kills accepted or in-flight op
//            src_a, src_b   - operands (src_a also carries MTHI/MTLO data)
//            busy           - divide in progress, pipeline must stall
//            done           - one-cycle pulse after a mult/div commit
//            hi_o, lo_o     - HI and LO registers
// Config   : HILO_MADD_EN enables MADD/MSUB accumulate on op codes 6/7;
//            without it those codes are no-ops.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic         cancel,
    input  logic [W-1:0] src_a,
    input  logic [W-1:0] src_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o
);
    state_t       r_state;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;
    logic         r_q_neg;
    logic         r_r_neg;
    logic         r_div_zero;

    logic           w_accept;
    logic           w_div_signed;
    logic           w_mul_signed;
    logic           w_b_zero;
    logic           w_div_start;
    logic           w_div_last;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_quo_fix;
    logic [W-1:0]   w_rem_fix;
    logic [2*W-1:0] w_ext_a;
    logic [2*W-1:0] w_ext_b;
    logic [2*W-1:0] w_prod;

    // busy is high exactly when the sequencer is outside IDLE.
    assign w_accept     = start && !cancel && (r_state == ST_IDLE);
    assign w_div_signed = (op == c_op_div);
    assign w_b_zero     = (src_b == '0);
    assign w_div_start  = w_accept && (op == c_op_div || op == c_op_divu) && !w_b_zero;

`ifdef HILO_MADD_EN
    assign w_mul_signed = (op == c_op_mult) ||
                          ((op == c_op_madd || op == c_op_msub) && !c_madd_unsigned);
`else
    assign w_mul_signed = (op == c_op_mult);
`endif

    // Extending to 2W bits first makes the truncated product correct for
    // both signed and unsigned operands.
    assign w_ext_a = w_mul_signed ? {{W{src_a[W-1]}}, src_a} : {{W{1'b0}}, src_a};
    assign w_ext_b = w_mul_signed ? {{W{src_b[W-1]}}, src_b} : {{W{1'b0}}, src_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_abs_a = (w_div_signed && src_a[W-1]) ? -src_a : src_a;
    assign w_abs_b = (w_div_signed && src_b[W-1]) ? -src_b : src_b;

    // -2^(W-1) / -1 yields 2^(W-1) unsigned with no negation: the natural wrap.
    assign w_quo_fix = r_q_neg ? -w_quo : w_quo;
    assign w_rem_fix = r_r_neg ? -w_rem : w_rem;

    iter_divider #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .cancel    (cancel),
        .dividend  (w_abs_a),
        .divisor   (w_abs_b),
        .last      (w_div_last),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (op)
                            c_op_mult, c_op_multu: begin
                                {r_hi, r_lo} <= w_prod;
                                r_done       <= 1'b1;
                            end
                            c_op_div, c_op_divu: begin
                                r_q_neg    <= w_div_signed & (src_a[W-1] ^ src_b[W-1]);
                                r_r_neg    <= w_div_signed & src_a[W-1];
                                r_div_zero <= w_b_zero;
                                r_busy     <= 1'b1;
                                // Divide-by-zero has nothing to iterate.
                                r_state    <= w_b_zero ? ST_DIV_FIX : ST_DIV_RUN;
                            end
                            c_op_mthi: r_hi <= src_a;
                            c_op_mtlo: r_lo <= src_a;
`ifdef HILO_MADD_EN
                            c_op_madd: begin
                                {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
                                r_done       <= 1'b1;
                            end
                            c_op_msub: begin
                                {r_hi, r_lo} <= {r_hi, r_lo} - w_prod;
                                r_done       <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_DIV_RUN: begin
                    if (cancel) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_div_last) begin
                        r_state <= ST_DIV_FIX;
                    end
                end
                ST_DIV_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    // A flush in the commit cycle wins over the write.
                    if (!cancel) begin
                        if (!r_div_zero) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire
